// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control unit: fetch/decode/execute/memory/writeback sequencing.
// Define CTRL_JAL_EN to add jal support through the SALTO_LINK state.
module controle_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemPronta,
  output logic       IouD,
  output logic       LerMem,
  output logic       EscMem,
  output logic       EscIR,
  output logic       PCEsc,
  output logic       EscReg,
  output logic [1:0] RegDst,
  output logic [1:0] MemParaReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] FontePC,
  output logic       Excecao,
  output logic [3:0] Estado
);

  localparam int unsigned CNT_W = 16;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  typedef enum logic [3:0] {
    BUSCA      = 4'd0,
    DECOD      = 4'd1,
    CALC_END   = 4'd2,
    LE_MEM     = 4'd3,
    ESC_LOAD   = 4'd4,
    ESC_STORE  = 4'd5,
    EXEC_R     = 4'd6,
    ESC_R      = 4'd7,
    DESVIO     = 4'd8,
    SALTO      = 4'd9,
    EXEC_I     = 4'd10,
    ESC_I      = 4'd11,
    SALTO_LINK = 4'd12,
    ERRO       = 4'd15
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_state;
  logic             timeout_hit;
  logic             funct_legal;

  // Only plain ALU R-type functions are executable; anything else traps.
  always_comb begin
    funct_legal = 1'b0;
    case (Funct)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011,
      6'b000000, 6'b000010, 6'b000011: funct_legal = 1'b1;
      default:                         funct_legal = 1'b0;
    endcase
  end

  assign wait_state  = (state == BUSCA) || (state == LE_MEM) || (state == ESC_STORE);
  // Fires on the wait cycle that would bring the count up to MEM_TIMEOUT; a ready in that cycle wins.
  assign timeout_hit = TIMEOUT_EN && wait_state && !MemPronta && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BUSCA;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter restarts on every state change so each access gets its own budget.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (wait_state && !MemPronta && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    IouD       = 1'b0;
    LerMem     = 1'b0;
    EscMem     = 1'b0;
    EscIR      = 1'b0;
    PCEsc      = 1'b0;
    EscReg     = 1'b0;
    RegDst     = 2'b00;
    MemParaReg = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    FontePC    = 2'b00;
    Excecao    = 1'b0;
    Estado     = state;

    case (state)
      BUSCA: begin
        LerMem  = 1'b1;
        ALUSrcB = 2'b01;
        if (timeout_hit) begin
          state_next = ERRO;
        end else if (MemPronta) begin
          EscIR      = 1'b1;
          PCEsc      = 1'b1;
          state_next = DECOD;
        end
      end
      DECOD: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:                          state_next = funct_legal ? EXEC_R : ERRO;
          OP_LW, OP_SW:                      state_next = CALC_END;
          OP_BEQ, OP_BNE:                    state_next = DESVIO;
          OP_J:                              state_next = SALTO;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = EXEC_I;
`ifdef CTRL_JAL_EN
          OP_JAL:                            state_next = SALTO_LINK;
`endif
          default:                           state_next = ERRO;
        endcase
      end
      CALC_END: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_SW) ? ESC_STORE : LE_MEM;
      end
      LE_MEM: begin
        IouD   = 1'b1;
        LerMem = 1'b1;
        if (timeout_hit) begin
          state_next = ERRO;
        end else if (MemPronta) begin
          state_next = ESC_LOAD;
        end
      end
      ESC_LOAD: begin
        EscReg     = 1'b1;
        MemParaReg = 2'b01;
        state_next = BUSCA;
      end
      ESC_STORE: begin
        IouD   = 1'b1;
        EscMem = 1'b1;
        if (timeout_hit) begin
          state_next = ERRO;
        end else if (MemPronta) begin
          state_next = BUSCA;
        end
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = ESC_R;
      end
      ESC_R: begin
        EscReg     = 1'b1;
        RegDst     = 2'b01;
        state_next = BUSCA;
      end
      EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = 2'b11;
        state_next = ESC_I;
      end
      ESC_I: begin
        EscReg     = 1'b1;
        state_next = BUSCA;
      end
      DESVIO: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        FontePC    = 2'b01;
        PCEsc      = (Opcode == OP_BNE) ? ~Zero : Zero;
        state_next = BUSCA;
      end
      SALTO: begin
        PCEsc      = 1'b1;
        FontePC    = 2'b10;
        state_next = BUSCA;
      end
`ifdef CTRL_JAL_EN
      SALTO_LINK: begin
        EscReg     = 1'b1;
        RegDst     = 2'b10;
        MemParaReg = 2'b10;
        PCEsc      = 1'b1;
        FontePC    = 2'b10;
        state_next = BUSCA;
      end
`endif
      ERRO: begin
        Excecao    = 1'b1;
        state_next = ERRO;
      end
      default: begin
        state_next = ERRO;
      end
    endcase

    // Reset silences every output in the same cycle and restarts at fetch.
    if (reset) begin
      state_next = BUSCA;
      IouD       = 1'b0;
      LerMem     = 1'b0;
      EscMem     = 1'b0;
      EscIR      = 1'b0;
      PCEsc      = 1'b0;
      EscReg     = 1'b0;
      RegDst     = 2'b00;
      MemParaReg = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      FontePC    = 2'b00;
      Excecao    = 1'b0;
      Estado     = 4'd0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo; build with CTRL_JAL_EN to exercise jal linking.
module tb_controle_multiciclo;

  logic       clock;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemPronta;
  logic       IouD, LerMem, EscMem, EscIR, PCEsc, EscReg, ALUSrcA, Excecao;
  logic [1:0] RegDst, MemParaReg, ALUSrcB, ALUOp, FontePC;
  logic [3:0] Estado;

  logic       reset_t;
  logic       pronta_t;
  logic       IouD_t, LerMem_t, EscMem_t, EscIR_t, PCEsc_t, EscReg_t, ALUSrcA_t, Excecao_t;
  logic [1:0] RegDst_t, MemParaReg_t, ALUSrcB_t, ALUOp_t, FontePC_t;
  logic [3:0] Estado_t;

  int total;
  int bad;

  controle_multiciclo u_dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemPronta(MemPronta), .IouD(IouD), .LerMem(LerMem), .EscMem(EscMem),
    .EscIR(EscIR), .PCEsc(PCEsc), .EscReg(EscReg), .RegDst(RegDst),
    .MemParaReg(MemParaReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .FontePC(FontePC), .Excecao(Excecao), .Estado(Estado)
  );

  controle_multiciclo #(.MEM_TIMEOUT(4)) u_dut_to (
    .clock(clock), .reset(reset_t), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemPronta(pronta_t), .IouD(IouD_t), .LerMem(LerMem_t), .EscMem(EscMem_t),
    .EscIR(EscIR_t), .PCEsc(PCEsc_t), .EscReg(EscReg_t), .RegDst(RegDst_t),
    .MemParaReg(MemParaReg_t), .ALUSrcA(ALUSrcA_t), .ALUSrcB(ALUSrcB_t), .ALUOp(ALUOp_t),
    .FontePC(FontePC_t), .Excecao(Excecao_t), .Estado(Estado_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed outputs packed as {Estado, IouD,LerMem,EscMem,EscIR,PCEsc,EscReg, RegDst, MemParaReg, ALUSrcA, ALUSrcB, ALUOp, FontePC, Excecao}.
  logic [21:0] obs;
  assign obs = {Estado, IouD, LerMem, EscMem, EscIR, PCEsc, EscReg, RegDst, MemParaReg,
                ALUSrcA, ALUSrcB, ALUOp, FontePC, Excecao};

  function automatic logic [21:0] ev(input logic [3:0] st, input logic [5:0] en,
                                     input logic [1:0] rd, input logic [1:0] mpr,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic [1:0] fp,
                                     input logic ex);
    return {st, en, rd, mpr, sa, sb, op, fp, ex};
  endfunction

  logic [21:0] V_BUSCA_W, V_BUSCA_R, V_DECOD, V_CALC, V_LE_MEM, V_ESC_LOAD, V_ESC_STORE;
  logic [21:0] V_EXEC_R, V_ESC_R, V_EXEC_I, V_ESC_I, V_DESV_NT, V_DESV_T, V_SALTO;
  logic [21:0] V_LINK, V_ERRO;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemPronta = 1'b1;
    tick();
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 22'd0);
    end
    reset = 1'b0;
    MemPronta = 1'b0;
    #1;
    total++;
    if (obs !== V_BUSCA_W) begin
      bad++;
      $display("FAIL reset_release: got %h expected %h", obs, V_BUSCA_W);
    end
  endtask

  task automatic test_add();
    logic [21:0] seq [5];
    seq = '{V_BUSCA_R, V_DECOD, V_EXEC_R, V_ESC_R, V_BUSCA_R};
    Opcode = 6'b000000;
    Funct = 6'b100000;
    MemPronta = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL add cycle %0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [21:0] seq [11];
    logic        pr  [11];
    int          escir_n;
    seq = '{V_BUSCA_W, V_BUSCA_W, V_BUSCA_R, V_DECOD, V_CALC, V_LE_MEM, V_LE_MEM,
            V_LE_MEM, V_LE_MEM, V_ESC_LOAD, V_BUSCA_R};
    pr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    escir_n = 0;
    Opcode = 6'b100011;
    for (int i = 0; i < 11; i++) begin
      MemPronta = pr[i];
      #1;
      if (i < 10) escir_n += int'(EscIR);
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 10) tick();
    end
    total++;
    if (escir_n !== 1) begin
      bad++;
      $display("FAIL lw_escir_pulses: got %0d expected 1", escir_n);
    end
  endtask

  task automatic test_sw();
    logic [21:0] seq [5];
    seq = '{V_BUSCA_R, V_DECOD, V_CALC, V_ESC_STORE, V_BUSCA_R};
    Opcode = 6'b101011;
    MemPronta = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL sw cycle %0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_imm();
    logic [5:0]  ops [4];
    logic [21:0] seq [4];
    ops = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    seq = '{V_BUSCA_R, V_DECOD, V_EXEC_I, V_ESC_I};
    MemPronta = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        total++;
        if (obs !== seq[i]) begin
          bad++;
          $display("FAIL imm op %b cycle %0d: got %h expected %h", ops[k], i, obs, seq[i]);
        end
        tick();
      end
    end
    #1;
    total++;
    if (obs !== V_BUSCA_R) begin
      bad++;
      $display("FAIL imm_return: got %h expected %h", obs, V_BUSCA_R);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4];
    logic        zs  [4];
    logic [21:0] dv  [4];
    ops = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
    zs  = '{1'b0, 1'b0, 1'b1, 1'b1};
    dv  = '{V_DESV_NT, V_DESV_T, V_DESV_T, V_DESV_NT};
    MemPronta = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Opcode = ops[k];
      Zero = zs[k];
      #1;
      total++;
      if (obs !== V_BUSCA_R) begin
        bad++;
        $display("FAIL branch %0d fetch: got %h expected %h", k, obs, V_BUSCA_R);
      end
      tick();
      #1;
      total++;
      if (obs !== V_DECOD) begin
        bad++;
        $display("FAIL branch %0d decode: got %h expected %h", k, obs, V_DECOD);
      end
      tick();
      #1;
      total++;
      if (obs !== dv[k]) begin
        bad++;
        $display("FAIL branch %0d desvio: got %h expected %h", k, obs, dv[k]);
      end
      tick();
    end
    Zero = 1'b0;
    #1;
    total++;
    if (obs !== V_BUSCA_R) begin
      bad++;
      $display("FAIL branch_return: got %h expected %h", obs, V_BUSCA_R);
    end
  endtask

  task automatic test_jump();
    logic [21:0] seq [4];
    seq = '{V_BUSCA_R, V_DECOD, V_SALTO, V_BUSCA_R};
    Opcode = 6'b000010;
    MemPronta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL j cycle %0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_jal();
    logic [21:0] seq [4];
`ifdef CTRL_JAL_EN
    seq = '{V_BUSCA_R, V_DECOD, V_LINK, V_BUSCA_R};
`else
    seq = '{V_BUSCA_R, V_DECOD, V_ERRO, V_ERRO};
`endif
    Opcode = 6'b000011;
    MemPronta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL jal cycle %0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i < 3) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    Opcode = 6'b100011;
    MemPronta = 1'b1;
    #1;
    tick();
    tick();
    #1;
    total++;
    if (obs !== V_CALC) begin
      bad++;
      $display("FAIL rst_mid calc: got %h expected %h", obs, V_CALC);
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++;
      $display("FAIL rst_mid forced: got %h expected %h", obs, 22'd0);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (obs !== V_BUSCA_R) begin
      bad++;
      $display("FAIL rst_mid restart: got %h expected %h", obs, V_BUSCA_R);
    end
  endtask

  task automatic test_illegal();
    Opcode = 6'b111111;
    MemPronta = 1'b1;
    #1;
    tick();
    tick();
    #1;
    total++;
    if (obs !== V_ERRO) begin
      bad++;
      $display("FAIL illegal cycle3: got %h expected %h", obs, V_ERRO);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      MemPronta = i[0];
      Opcode = 6'b000000;
      #1;
      total++;
      if (obs !== V_ERRO) begin
        bad++;
        $display("FAIL illegal hold %0d: got %h expected %h", i, obs, V_ERRO);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    MemPronta = 1'b0;
    #1;
    total++;
    if (obs !== V_BUSCA_W) begin
      bad++;
      $display("FAIL illegal_recover: got %h expected %h", obs, V_BUSCA_W);
    end
  endtask

  task automatic test_timeout();
    MemPronta = 1'b0;
    Opcode = 6'b000000;
    Funct = 6'b100000;
    reset_t = 1'b1;
    tick();
    reset_t = 1'b0;
    pronta_t = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++;
      if ({Estado_t, Excecao_t} !== 5'b0000_0) begin
        bad++;
        $display("FAIL timeout wait %0d: got %h expected 00", i, {Estado_t, Excecao_t});
      end
      tick();
    end
    #1;
    total++;
    if ({Estado_t, Excecao_t} !== 5'b1111_1) begin
      bad++;
      $display("FAIL timeout_erro: got %h expected 1f", {Estado_t, Excecao_t});
    end
    reset_t = 1'b1;
    tick();
    reset_t = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pronta_t = (i == 4);
      #1;
      total++;
      if ({Estado_t, EscIR_t} !== {4'd0, pronta_t}) begin
        bad++;
        $display("FAIL ready_wins wait %0d: got %h expected %h", i, {Estado_t, EscIR_t}, {4'd0, pronta_t});
      end
      tick();
    end
    #1;
    total++;
    if ({Estado_t, Excecao_t} !== 5'b0001_0) begin
      bad++;
      $display("FAIL ready_wins_decod: got %h expected 02", {Estado_t, Excecao_t});
    end
    reset_t = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    reset_t = 1'b1;
    pronta_t = 1'b0;
    Opcode = 6'b000000;
    Funct = 6'b100000;
    Zero = 1'b0;
    MemPronta = 1'b0;

    V_BUSCA_W   = ev(4'd0,  6'b010000, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    V_BUSCA_R   = ev(4'd0,  6'b010110, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    V_DECOD     = ev(4'd1,  6'b000000, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
    V_CALC      = ev(4'd2,  6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    V_LE_MEM    = ev(4'd3,  6'b110000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    V_ESC_LOAD  = ev(4'd4,  6'b000001, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    V_ESC_STORE = ev(4'd5,  6'b101000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    V_EXEC_R    = ev(4'd6,  6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0);
    V_ESC_R     = ev(4'd7,  6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    V_DESV_NT   = ev(4'd8,  6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0);
    V_DESV_T    = ev(4'd8,  6'b000010, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0);
    V_SALTO     = ev(4'd9,  6'b000010, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
    V_EXEC_I    = ev(4'd10, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b11, 2'b00, 1'b0);
    V_ESC_I     = ev(4'd11, 6'b000001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    V_LINK      = ev(4'd12, 6'b000011, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
    V_ERRO      = ev(4'd15, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_imm();
    test_branch();
    test_jump();
    test_reset_mid();
    test_jal();
    test_illegal();
    test_timeout();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle MIPS main control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables: the register-file write strobe `EscReg`, the PC/IR/memory enables and the mux selects. It sits directly upstream of the register bank and handshakes with instruction/data memory through a ready strobe.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles for `MemPronta` per access; 0 disables the timeout.
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `Opcode` in 6: IR[31:26], stable from DECOD until the next BUSCA.
- `Funct` in 6: IR[5:0]; used only for the R-type legality check.
- `Zero` in 1: ALU zero flag.
- `MemPronta` in 1: memory ready/ack for the current access.
- `IouD` out 1: memory address source, 0=PC, 1=ALUOut.
- `LerMem` out 1: memory read request.
- `EscMem` out 1: memory write request.
- `EscIR` out 1: IR load enable.
- `PCEsc` out 1: PC write enable; includes the branch condition.
- `EscReg` out 1: register-file write enable.
- `RegDst` out 2: destination select, 00=rt, 01=rd, 10=$31.
- `MemParaReg` out 2: write-data select, 00=ALUOut, 01=MDR, 10=PC.
- `ALUSrcA` out 1: 0=PC, 1=A.
- `ALUSrcB` out 2: 00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2.
- `ALUOp` out 2: 00=add, 01=sub, 10=funct-decoded, 11=immediate-op (opcode-decoded).
- `FontePC` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `Excecao` out 1: sticky illegal-instruction or memory-timeout flag.
- `Estado` out 4: current state encoding, for debug.

## Operation
- **States and encodings:** BUSCA=0, DECOD=1, CALC_END=2, LE_MEM=3, ESC_LOAD=4, ESC_STORE=5, EXEC_R=6, ESC_R=7, DESVIO=8, SALTO=9, EXEC_I=10, ESC_I=11, SALTO_LINK=12, ERRO=15.
- **BUSCA:** IouD=0, LerMem=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, FontePC=00.
  - While MemPronta=0: stay in BUSCA.
  - On MemPronta=1, in the same cycle: EscIR=1 and PCEsc=1 (Mealy), then go to DECOD.
- **DECOD:** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on Opcode:
  - 000000 → EXEC_R.
  - 100011 (lw) or 101011 (sw) → CALC_END.
  - 000100 (beq) or 000101 (bne) → DESVIO.
  - 000010 (j) → SALTO.
  - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) → EXEC_I.
  - 000011 (jal) → SALTO_LINK, only when the macro is defined.
  - Any other opcode → ERRO.
- **CALC_END:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to LE_MEM for lw, ESC_STORE for sw.
- **LE_MEM:** IouD=1, LerMem=1; wait for MemPronta, then go to ESC_LOAD.
- **ESC_LOAD:** EscReg=1, RegDst=00, MemParaReg=01; then BUSCA.
- **ESC_STORE:** IouD=1, EscMem=1; wait for MemPronta, then BUSCA.
- **EXEC_R:** ALUSrcA=1, ALUSrcB=00, ALUOp=10; then ESC_R.
- **ESC_R:** EscReg=1, RegDst=01, MemParaReg=00; then BUSCA.
- **EXEC_I:** ALUSrcA=1, ALUSrcB=10, ALUOp=11; then ESC_I.
- **ESC_I:** EscReg=1, RegDst=00, MemParaReg=00; then BUSCA.
- **DESVIO:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, FontePC=01.
  - PCEsc=Zero for beq, PCEsc=~Zero for bne.
  - Then BUSCA.
- **SALTO:** PCEsc=1, FontePC=10; then BUSCA.
- **ERRO:**
  - All enables are 0 and Excecao=1.
  - ERRO is absorbing until reset.
- **Defaults:** every output not listed for a state is 0.
- **Memory timeout:**
  - A 16-bit wait counter clears on entry to BUSCA, LE_MEM or ESC_STORE, and increments each cycle MemPronta=0 while in one of those states.
  - When the count reaches MEM_TIMEOUT (MEM_TIMEOUT≠0): next state is ERRO and no enable fires that cycle.
  - MemPronta=1 in that same cycle wins; the access completes normally.
- **MemPronta outside wait states:** ignored.

## Timing
- **Reset:**
  - Any cycle with reset=1 forces next state BUSCA, clears Excecao and clears the wait counter.
  - While reset=1, all outputs are forced to 0, including LerMem and Estado (reads 0).
  - Reset mid-instruction abandons it; no partial write follows.
- **Cycles per instruction, MemPronta=1 on first request:**
  - 3 cycles: beq/bne, j, jal.
  - 4 cycles: R-type, immediate ops, sw.
  - 5 cycles: lw.
  - Each memory wait cycle adds 1.
- **EscReg:**
  - High for exactly one cycle per writing instruction: in ESC_R, ESC_LOAD, ESC_I or SALTO_LINK.
  - Write data and address are stable for that whole cycle.
- **Output decoding:** outputs are Moore-decoded from the state register, except EscIR/PCEsc in BUSCA and PCEsc in DESVIO, which are combinational on MemPronta/Zero.

## Configuration
- `CTRL_JAL_EN` defined:
  - Opcode 000011 → SALTO_LINK.
  - In SALTO_LINK, in one cycle: EscReg=1, RegDst=10, MemParaReg=10 (PC+4 into $31), PCEsc=1, FontePC=10; then BUSCA.
- `CTRL_JAL_EN` undefined:
  - Opcode 000011 → ERRO.
  - State 12 is unreachable.

## Test plan
- **add:** Opcode=000000, Funct=100000, MemPronta always 1 → Estado sequence 0,1,6,7,0; EscReg=1 only in state 7 with RegDst=01.
- **lw with wait states:** lw with MemPronta low 2 cycles in BUSCA and 3 in LE_MEM → 10 cycles total; EscIR pulses exactly once; EscReg=1 with MemParaReg=01 in state 4.
- **Branches:**
  - beq with Zero=0 → PCEsc=0 in state 8.
  - bne with Zero=0 → PCEsc=1 in state 8.
  - Both return to BUSCA.
- **Illegal opcode:** Opcode=111111 → ERRO at cycle 3; Excecao=1 held for 20 cycles; reset=1 for one cycle → Estado=0, Excecao=0.
- **Timeout:** MEM_TIMEOUT=4, MemPronta stuck 0 in BUSCA → ERRO after 4 wait cycles; the same run with MemPronta=1 on the 4th cycle → DECOD.
- **jal:** with CTRL_JAL_EN, jal → states 0,1,12 with EscReg=1, RegDst=10, PCEsc=1; without the macro → ERRO.
